pq_arbiter: RTL and testbench

PQ_ARBITER -- requirements
Module: pq_arbiter

---
 rtl/pq_pkg.sv | 20 ++
 rtl/pq_if.sv | 16 +
 rtl/pq_arbiter_wrap.sv | 36 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/pq_arbiter.sv | 125 ++++++++++++
 tb/tb_pq_arbiter.sv | 288 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - key/value types and arbiter state encoding shared by the priority-queue block
package pq_pkg;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;

  // key is the priority field; the queue returns the smallest key first
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/pq_if.sv
// rtl/pq_if.sv - strobe/status bundle between the arbiter and the shared priority queue
interface pq_if;
  import pq_pkg::*;

  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic full;
  logic empty;
  logic busy;

  modport arb   (output enq, deq, kvi, input full, empty, busy, kvo);
  modport queue (input enq, deq, kvi, output full, empty, busy, kvo);

endinterface

// File: rtl/pq_arbiter_wrap.sv
// rtl/pq_arbiter_wrap.sv - binds pq_arbiter to the shared queue through pq_if
module pq_arbiter_wrap
  import pq_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_enq,
  input  logic [NREQ-1:0] req_deq,
  input  kv_t  [NREQ-1:0] req_kv,
  output logic [NREQ-1:0] ack,
  output logic            ack_err,
  output kv_t             ack_kv,
  pq_if.arb               pq
);

  pq_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_enq  (req_enq),
    .req_deq  (req_deq),
    .req_kv   (req_kv),
    .ack      (ack),
    .ack_err  (ack_err),
    .ack_kv   (ack_kv),
    .pq_enq   (pq.enq),
    .pq_deq   (pq.deq),
    .pq_kvi   (pq.kvi),
    .pq_full  (pq.full),
    .pq_empty (pq.empty),
    .pq_busy  (pq.busy),
    .pq_kvo   (pq.kvo)
  );

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin selector: first active request at or above ptr, with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [NREQ-1:0] rot;
  int              s;

  // rotate so bit 0 of rot is the requester at ptr
  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    s     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        s     = int'(ptr) + i;
        if (s >= NREQ) s = s - NREQ;
        idx   = IW'(s);
      end
    end
    gnt = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/pq_arbiter.sv
// rtl/pq_arbiter.sv - serialises per-requester enqueue/dequeue requests onto one shared priority queue
module pq_arbiter
  import pq_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_enq,
  input  logic [NREQ-1:0] req_deq,
  input  kv_t  [NREQ-1:0] req_kv,
  output logic [NREQ-1:0] ack,
  output logic            ack_err,
  output kv_t             ack_kv,
  output logic            pq_enq,
  output logic            pq_deq,
  output kv_t             pq_kvi,
  input  logic            pq_full,
  input  logic            pq_empty,
  input  logic            pq_busy,
  input  kv_t             pq_kvo
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic            op_enq_q, op_enq_d;
  logic            err_q, err_d;
  kv_t             kv_q, kv_d;
  kv_t             ack_kv_q, ack_kv_d;

  logic [NREQ-1:0] sel_gnt;
  logic [IW-1:0]   sel_idx;
  logic            sel_valid;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (req_enq | req_deq),
    .ptr   (rr_ptr_q),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  assign ack_kv = ack_kv_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    op_enq_d  = op_enq_q;
    err_d     = err_q;
    kv_d      = kv_q;
    ack_kv_d  = ack_kv_q;
    pq_enq    = 1'b0;
    pq_deq    = 1'b0;
    pq_kvi    = '0;
    ack       = '0;
    ack_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // grant is latched so a requester dropping its line cannot abort the operation
        if (sel_valid && !pq_busy) begin
          gnt_idx_d = sel_idx;
          op_enq_d  = |(sel_gnt & req_enq);
          kv_d      = req_kv[sel_idx];
          err_d     = 1'b0;
          rr_ptr_d  = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_enq_q) begin
          if (pq_full) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            pq_enq  = 1'b1;
            pq_kvi  = kv_q;
            state_d = ST_WAIT;
          end
        end else if (pq_empty) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          pq_deq   = 1'b1;
          ack_kv_d = pq_kvo;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!pq_busy) state_d = ST_RESP;
      end
      ST_RESP: begin
        ack     = NREQ'(1) << gnt_idx_q;
        ack_err = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      op_enq_q  <= 1'b0;
      err_q     <= 1'b0;
      kv_q      <= '0;
      ack_kv_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      op_enq_q  <= op_enq_d;
      err_q     <= err_d;
      kv_q      <= kv_d;
      ack_kv_q  <= ack_kv_d;
    end
  end

endmodule

// File: tb/tb_pq_arbiter.sv
// tb/tb_pq_arbiter.sv - self-checking bench for pq_arbiter against a behavioural min-first queue
module tb_pq_arbiter;
  import pq_pkg::*;

  localparam int N   = 4;
  localparam int CAP = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req_enq = '0;
  logic [N-1:0] req_deq = '0;
  kv_t  [N-1:0] req_kv = '0;
  logic [N-1:0] ack;
  logic         ack_err;
  kv_t          ack_kv;
  logic         pq_enq, pq_deq;
  kv_t          pq_kvi;
  logic         pq_full = 1'b0;
  logic         pq_empty = 1'b1;
  logic         pq_busy = 1'b0;
  kv_t          pq_kvo = '0;

  int checks = 0;
  int failures = 0;

  logic [15:0] qm[$];
  int          enq_cnt = 0, deq_cnt = 0, clash_cnt = 0;
  int          busy_cnt = 0, busy_arm = 0, busy_len = 0;
  logic        pend_enq = 1'b0, pend_deq = 1'b0;
  logic [15:0] pend_kv = '0, last_kvi = '0;

  int          rr_ptr_m = 0;
  logic [15:0] last_ackkv = '0;

  pq_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_enq(req_enq), .req_deq(req_deq), .req_kv(req_kv),
    .ack(ack), .ack_err(ack_err), .ack_kv(ack_kv),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy), .pq_kvo(pq_kvo)
  );

  always #5 clk = ~clk;

  // shared queue model: strobe seen mid-cycle, applied one cycle later, then optional busy window
  always @(negedge clk) begin
    if (!rst) begin
      qm.delete();
      pend_enq = 1'b0;
      pend_deq = 1'b0;
      busy_cnt = 0;
      busy_arm = 0;
    end else begin
      if (pend_enq) begin
        int pos;
        pos = qm.size();
        for (int i = 0; i < qm.size(); i++) begin
          if (qm[i][15:8] > pend_kv[15:8]) begin
            pos = i;
            break;
          end
        end
        qm.insert(pos, pend_kv);
      end
      if (pend_deq && qm.size() > 0) void'(qm.pop_front());
      pend_enq = 1'b0;
      pend_deq = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (busy_arm > 0) begin
        busy_cnt = busy_arm;
        busy_arm = 0;
      end
      if (pq_enq && pq_deq) clash_cnt++;
      if (pq_enq) begin
        pend_enq = 1'b1; pend_kv = pq_kvi; last_kvi = pq_kvi; enq_cnt++; busy_arm = busy_len;
      end
      if (pq_deq) begin
        pend_deq = 1'b1; deq_cnt++; busy_arm = busy_len;
      end
    end
    pq_busy  = (busy_cnt > 0);
    pq_full  = (qm.size() >= CAP);
    pq_empty = (qm.size() == 0);
    pq_kvo   = (qm.size() > 0) ? kv_t'(qm[0]) : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int exp_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == '0 && lat < 40);
    chk("ack_seen", {31'd0, |ack}, 32'd1);
  endtask

  task automatic do_op(input int idx, input bit is_enq, input logic [15:0] kv, input int blen,
                       output logic [15:0] got_kv);
    int          e0, d0, lat, exp_lat;
    bit          exp_err;
    logic [15:0] exp_kv;
    exp_err  = is_enq ? (qm.size() >= CAP) : (qm.size() == 0);
    exp_kv   = (!is_enq && !exp_err) ? qm[0] : last_ackkv;
    exp_lat  = exp_err ? 2 : 3 + blen;
    busy_len = blen;
    e0 = enq_cnt;
    d0 = deq_cnt;
    req_kv[idx] = kv_t'(kv);
    if (is_enq) req_enq[idx] = 1'b1;
    else        req_deq[idx] = 1'b1;
    wait_ack(lat);
    req_enq[idx] = 1'b0;
    req_deq[idx] = 1'b0;
    chk("ack_vec", 32'(ack), 32'(onehot(idx)));
    chk("ack_err", 32'(ack_err), 32'(exp_err));
    chk("latency", lat, exp_lat);
    chk("enq_strobes", enq_cnt - e0, (is_enq && !exp_err) ? 1 : 0);
    chk("deq_strobes", deq_cnt - d0, (!is_enq && !exp_err) ? 1 : 0);
    if (is_enq && !exp_err) chk("pq_kvi", 32'(last_kvi), 32'(kv));
    if (!is_enq && !exp_err) begin
      chk("ack_kv", 32'(ack_kv), 32'(exp_kv));
      last_ackkv = exp_kv;
    end
    got_kv   = ack_kv;
    rr_ptr_m = (idx + 1) % N;
    @(negedge clk);
    chk("ack_pulse", 32'(ack), 32'd0);
    chk("ack_err_idle", 32'(ack_err), 32'd0);
    chk("ack_kv_hold", 32'(ack_kv), 32'(last_ackkv));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    rr_ptr_m   = 0;
    last_ackkv = '0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] got;
    logic [7:0]  order_keys[3];
    int          lat, e0, d0, g;
    bit          stray;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_ack_kv", 32'(ack_kv), 32'd0);
    chk("rst_pq_enq", 32'(pq_enq), 32'd0);
    chk("rst_pq_deq", 32'(pq_deq), 32'd0);
    chk("rst_pq_kvi", 32'(pq_kvi), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);

    // single enqueue from requester 1
    do_op(1, 1'b1, 16'h05_11, 0, got);

    // min-first ordering
    do_op(0, 1'b0, 16'h0, 0, got);
    chk("first_deq_key", 32'(got[15:8]), 32'h05);
    do_op(0, 1'b1, 16'h09_a0, 0, got);
    do_op(1, 1'b1, 16'h03_a1, 0, got);
    do_op(2, 1'b1, 16'h07_a2, 0, got);
    order_keys[0] = 8'h03; order_keys[1] = 8'h07; order_keys[2] = 8'h09;
    for (int k = 0; k < 3; k++) begin
      do_op(3, 1'b0, 16'h0, 0, got);
      chk("min_order", 32'(got[15:8]), 32'(order_keys[k]));
    end

    // one requester with both lines: enqueue served before dequeue
    e0 = enq_cnt; d0 = deq_cnt;
    busy_len = 0;
    req_kv[2] = kv_t'(16'h44_bb);
    req_enq[2] = 1'b1; req_deq[2] = 1'b1;
    wait_ack(lat);
    req_enq[2] = 1'b0;
    chk("both_first_enq", enq_cnt - e0, 1);
    chk("both_first_nodeq", deq_cnt - d0, 0);
    wait_ack(lat);
    req_deq[2] = 1'b0;
    chk("both_then_deq", deq_cnt - d0, 1);
    chk("both_deq_kv", 32'(ack_kv), 32'h44bb);
    chk("both_ack_vec", 32'(ack), 32'(onehot(2)));
    last_ackkv = 16'h44bb;
    rr_ptr_m = 3;
    @(negedge clk);

    // refusals: dequeue on empty, enqueue on full
    do_op(2, 1'b0, 16'h0, 0, got);
    for (int r = 0; r < CAP; r++) do_op(r, 1'b1, 16'(($urandom_range(0, 255) << 8) | r), 0, got);
    do_op(0, 1'b1, 16'h01_ff, 0, got);

    // long busy window after the strobe
    do_op(1, 1'b0, 16'h0, 5, got);

    // fairness with all enqueue lines held from reset
    do_reset();
    busy_len = 0;
    for (int r = 0; r < N; r++) req_kv[r] = kv_t'(16'($urandom));
    req_enq = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(lat);
      g = exp_grant(req_enq, rr_ptr_m);
      chk("rr_order", 32'(ack), 32'(onehot(g)));
      rr_ptr_m = (g + 1) % N;
      if (k == 4) req_enq = '0;
    end
    @(negedge clk);
    chk("rr_quiet", 32'(ack), 32'd0);

    // randomized single-requester traffic
    for (int k = 0; k < 40; k++) begin
      do_op($urandom_range(0, N - 1), ($urandom_range(0, 99) < 55), 16'($urandom),
            $urandom_range(0, 3), got);
    end

    // reset while waiting on a busy queue
    busy_len = 3;
    req_kv[2] = kv_t'(16'h2a_2a);
    req_enq[2] = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wrst_ack", 32'(ack), 32'd0);
    chk("wrst_ack_err", 32'(ack_err), 32'd0);
    chk("wrst_ack_kv", 32'(ack_kv), 32'd0);
    chk("wrst_pq_enq", 32'(pq_enq), 32'd0);
    chk("wrst_pq_deq", 32'(pq_deq), 32'd0);
    chk("wrst_pq_kvi", 32'(pq_kvi), 32'd0);
    req_enq = '0;
    #1 rst = 1'b1;
    rr_ptr_m = 0;
    last_ackkv = '0;
    busy_len = 0;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack != '0) stray = 1'b1;
    end
    chk("wrst_no_ack", 32'(stray), 32'd0);
    req_enq = 4'b1010;
    wait_ack(lat);
    g = exp_grant(req_enq, rr_ptr_m);
    chk("wrst_rr_first", 32'(ack), 32'(onehot(g)));
    req_enq[g] = 1'b0;
    rr_ptr_m = (g + 1) % N;
    wait_ack(lat);
    g = exp_grant(req_enq, rr_ptr_m);
    chk("wrst_rr_second", 32'(ack), 32'(onehot(g)));
    req_enq = '0;
    @(negedge clk);

    chk("no_dual_strobe", clash_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
